// File: rtl/cla_adder_pkg.sv
// Shared constants for the registered carry-lookahead adder and its 4-bit group unit.
package cla_adder_pkg;

   localparam int unsigned GROUP_W = 4;

   function automatic int unsigned num_groups(input int unsigned width);
      return width / GROUP_W;
   endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead unit: flattened in-group carries plus group generate/propagate.
module cla_group4
   import cla_adder_pkg::*;
(
   input  logic [GROUP_W-1:0] a,
   input  logic [GROUP_W-1:0] b,
   input  logic               cin,
   output logic [GROUP_W-1:0] s,
   output logic               G,
   output logic               P
);

   logic [GROUP_W-1:0] g;
   logic [GROUP_W-1:0] p;
   logic [GROUP_W-1:0] c;

   // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
   always_comb begin
      g = a & b;
      p = a ^ b;

      // Each carry is a two-level sum of products of the group carry-in; nothing ripples.
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

      s = p ^ c;
      G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      P = &p;
   end

endmodule

// File: rtl/cla_adder.sv
// Two-stage registered carry-lookahead adder: input registers, WIDTH/4 lookahead groups
// joined by a second-level group-carry lookahead, then output registers.
module cla_adder
   import cla_adder_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic [WIDTH-1:0] A1,
   output logic [WIDTH-1:0] B1,
   output logic             Cin1
);

   localparam int NG = int'(num_groups(WIDTH));

   if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("cla_adder: WIDTH must be a positive multiple of 4");
   end

   logic [WIDTH-1:0] a1_d, a1_q;
   logic [WIDTH-1:0] b1_d, b1_q;
   logic             cin1_d, cin1_q;
   logic [WIDTH-1:0] s_d, s_q;
   logic             cout_d, cout_q;

   logic [NG-1:0]    grp_g;
   logic [NG-1:0]    grp_p;
   logic [NG:0]      grp_c;
   logic [WIDTH-1:0] sum;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group4 u_grp (
         .a   (a1_q[k*GROUP_W +: GROUP_W]),
         .b   (b1_q[k*GROUP_W +: GROUP_W]),
         .cin (grp_c[k]),
         .s   (sum[k*GROUP_W +: GROUP_W]),
         .G   (grp_g[k]),
         .P   (grp_p[k])
      );
   end

   // Group carry j = OR over m<j of (G[m] & P[m+1..j-1]) | (P[0..j-1] & cin1), fully flattened.
   always_comb begin
      grp_c    = '0;
      grp_c[0] = cin1_q;
      for (int j = 1; j <= NG; j++) begin
         logic acc;
         logic pall;
         acc  = 1'b0;
         pall = 1'b1;
         for (int m = j - 1; m >= 0; m--) begin
            acc  = acc | (pall & grp_g[m]);
            pall = pall & grp_p[m];
         end
         grp_c[j] = acc | (pall & cin1_q);
      end
   end

   always_comb begin
      a1_d   = A;
      b1_d   = B;
      cin1_d = Cin;
      s_d    = sum;
      cout_d = grp_c[NG];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q   <= '0;
         b1_q   <= '0;
         cin1_q <= 1'b0;
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         a1_q   <= a1_d;
         b1_q   <= b1_d;
         cin1_q <= cin1_d;
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign A1   = a1_q;
   assign B1   = b1_q;
   assign Cin1 = cin1_q;
   assign S    = s_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_cla_adder.sv
// Directed and swept checks of cla_adder at WIDTH=4 (exhaustive) and WIDTH=16 (random).
module tb_cla_adder;

   logic        clk;
   logic        rst_n;

   logic [3:0]  a4, b4, s4, a1_4, b1_4;
   logic        c4, cout4, cin1_4;
   logic [15:0] a16, b16, s16, a1_16, b1_16;
   logic        c16, cout16, cin1_16;

   int checks_total  = 0;
   int checks_passed = 0;

   cla_adder #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a4),
      .B     (b4),
      .Cin   (c4),
      .S     (s4),
      .Cout  (cout4),
      .A1    (a1_4),
      .B1    (b1_4),
      .Cin1  (cin1_4)
   );

   cla_adder #(.WIDTH(16)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (a16),
      .B     (b16),
      .Cin   (c16),
      .S     (s16),
      .Cout  (cout16),
      .A1    (a1_16),
      .B1    (b1_16),
      .Cin1  (cin1_16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   logic [4:0]  q4[$];
   logic [16:0] q16[$];

   initial begin
      rst_n = 1'b0;
      a4 = 4'h9;  b4 = 4'h6;  c4 = 1'b1;
      a16 = 16'hBEEF; b16 = 16'h1234; c16 = 1'b1;

      // Reset held across an edge: everything stays zero despite nonzero inputs.
      @(posedge clk); #1;
      check("rst_a1",   a1_4,  0);
      check("rst_b1",   b1_4,  0);
      check("rst_cin1", cin1_4, 0);
      check("rst_s",    s4,    0);
      check("rst_cout", cout4, 0);
      check("rst_s16",  {cout16, s16}, 0);

      @(negedge clk);
      rst_n = 1'b1;
      a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
      a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;

      @(negedge clk);
      check("in_a1",   a1_4,   4'hF);
      check("in_b1",   b1_4,   4'hF);
      check("in_cin1", cin1_4, 1);
      check("in_a1_16", a1_16, 16'hFFFF);
      a4 = 4'hA; b4 = 4'hC; c4 = 1'b1;
      a16 = 16'h0000; b16 = 16'h0000; c16 = 1'b0;

      @(negedge clk);
      check("ones4",  {cout4, s4},   5'h1F);
      check("ones16", {cout16, s16}, 17'h1FFFF);
      a4 = 4'hA; b4 = 4'h8; c4 = 1'b0;
      a16 = 16'h00FF; b16 = 16'h0001; c16 = 1'b0;

      @(negedge clk);
      check("a+c+1",  {cout4, s4},   5'd23);
      check("zero16", {cout16, s16}, 17'h0);
      a4 = 4'h1; b4 = 4'h1; c4 = 1'b0;
      a16 = 16'h7FFF; b16 = 16'h8000; c16 = 1'b1;

      @(negedge clk);
      check("a+8",      {cout4, s4},   5'd18);
      check("grp_carry", {cout16, s16}, 17'h00100);
      a4 = 4'h7; b4 = 4'h8; c4 = 1'b1;

      @(negedge clk);
      check("b2b_1",    {cout4, s4},   5'd2);
      check("carry_all", {cout16, s16}, 17'h10000);
      a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

      @(negedge clk);
      check("b2b_2", {cout4, s4}, 5'd16);

      @(negedge clk);
      check("zero4", {cout4, s4}, 5'd0);

      // Exhaustive WIDTH=4 sweep and random WIDTH=16, results due two edges after drive.
      for (int i = 0; i < 514; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("sweep4", {cout4, s4},   q4.pop_front());
            check("rand16", {cout16, s16}, q16.pop_front());
         end
         if (i < 512) begin
            logic [8:0] v;
            v = i[8:0];
            a4 = v[8:5]; b4 = v[4:1]; c4 = v[0];
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            q4.push_back(5'(a4) + 5'(b4) + 5'(c4));
            q16.push_back(17'(a16) + 17'(b16) + 17'(c16));
         end
      end

      // Asynchronous reset asserted mid-cycle discards in-flight data immediately.
      a4 = 4'hC; b4 = 4'h5; c4 = 1'b1;
      a16 = 16'hA5A5; b16 = 16'h5A5A; c16 = 1'b1;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_a1",   a1_4,   0);
      check("mid_b1",   b1_4,   0);
      check("mid_cin1", cin1_4, 0);
      check("mid_sum",  {cout4, s4}, 0);
      check("mid_a1_16", a1_16, 0);
      check("mid_sum16", {cout16, s16}, 0);
      @(posedge clk); #1;
      check("hold_sum", {cout4, s4}, 0);

      @(negedge clk);
      rst_n = 1'b1;
      a4 = 4'h3; b4 = 4'h5; c4 = 1'b1;
      a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b0;
      @(negedge clk);
      check("rel_a1", a1_4, 4'h3);
      @(negedge clk);
      check("rel_sum",   {cout4, s4},   5'd9);
      check("rel_sum16", {cout16, s16}, 17'h05555);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
